// File: rtl/reg_dst_queue_if.sv
// Interface bundling the instruction fields, destination select, queue
// handshake and status/hazard outputs of reg_dst_queue.
// master: issue/write-back side driving the queue; slave: the queue itself.
interface reg_dst_queue_if #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        reg_dst;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] dst_out;
    logic              dst_valid;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push_err;
    logic              pop_err;
    logic              hazard_rs;
    logic              hazard_rt;

    modport master (
        output rs_addr, rt_addr, rd_addr, reg_dst, push, pop,
        input  dst_out, dst_valid, count, full, empty,
        input  push_err, pop_err, hazard_rs, hazard_rt
    );

    modport slave (
        input  rs_addr, rt_addr, rd_addr, reg_dst, push, pop,
        output dst_out, dst_valid, count, full, empty,
        output push_err, pop_err, hazard_rs, hazard_rt
    );
endinterface

// File: rtl/reg_dst_queue.sv
// Register-destination selector feeding an in-order queue of outstanding
// register writes. The head entry is presented show-ahead (registered) for
// the write-back stage, which pops it as each write commits.
// Optional macro REG_DST_HAZARD_CHECK_EN enables RAW hazard flags on rs/rt
// against all occupied entries; without it the hazard outputs are tied low.
module reg_dst_queue #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 4,
    parameter int LINK_REG = 31,
    parameter int SP_REG   = 29
) (
    input  logic           clk,
    input  logic           reset_n,
    reg_dst_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [ADDR_W-1:0] sel;
    logic [ADDR_W-1:0] head_next;
    logic              is_full;
    logic              is_empty;
    logic              do_push;
    logic              do_pop;

    // Destination select decode; reserved codes map to index 0 (discarded write).
    always_comb begin
        sel = '0;
        case (q.reg_dst)
            3'b000:  sel = q.rs_addr;
            3'b001:  sel = ADDR_W'(LINK_REG);
            3'b010:  sel = ADDR_W'(SP_REG);
            3'b011:  sel = q.rt_addr;
            3'b100:  sel = q.rd_addr;
            default: sel = '0;
        endcase
    end

    assign is_full  = (cnt == CNT_W'(DEPTH));
    assign is_empty = (cnt == '0);
    // A push into a full queue is still legal when a pop frees the head slot.
    assign do_push  = q.push && (!is_full || q.pop);
    assign do_pop   = q.pop && !is_empty;
    assign rd_next  = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    // Next occupancy from accepted push/pop.
    always_comb begin
        cnt_next = cnt;
        if (do_push && !do_pop)
            cnt_next = cnt + CNT_W'(1);
        else if (!do_push && do_pop)
            cnt_next = cnt - CNT_W'(1);
    end

    // Next head value: bypass the incoming entry when it lands at the new head.
    always_comb begin
        head_next = '0;
        if (cnt_next != '0) begin
            if (do_push && (wr_ptr == rd_next))
                head_next = sel;
            else
                head_next = mem[rd_next];
        end
    end

    // Queue storage, pointers, registered head and error pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            q.dst_out  <= '0;
            q.push_err <= 1'b0;
            q.pop_err  <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= sel;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_next;
            cnt        <= cnt_next;
            q.dst_out  <= head_next;
            q.push_err <= q.push && is_full && !q.pop;
            q.pop_err  <= q.pop && is_empty;
        end
    end

    assign q.count     = cnt;
    assign q.full      = is_full;
    assign q.empty     = is_empty;
    assign q.dst_valid = !is_empty;

`ifdef REG_DST_HAZARD_CHECK_EN
    logic [PTR_W-1:0] off;
    logic             hz_rs;
    logic             hz_rt;

    // Compare rs/rt against every occupied slot; index 0 never hazards.
    always_comb begin
        hz_rs = 1'b0;
        hz_rt = 1'b0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr;
            if (CNT_W'(off) < cnt) begin
                if ((q.rs_addr != '0) && (mem[i] == q.rs_addr))
                    hz_rs = 1'b1;
                if ((q.rt_addr != '0) && (mem[i] == q.rt_addr))
                    hz_rt = 1'b1;
            end
        end
    end

    assign q.hazard_rs = hz_rs;
    assign q.hazard_rt = hz_rt;
`else
    assign q.hazard_rs = 1'b0;
    assign q.hazard_rt = 1'b0;
`endif
endmodule

// File: tb/tb_reg_dst_queue.sv
// Self-checking bench for reg_dst_queue: directed steps from the test plan
// followed by random push/pop traffic, all compared against a queue model.
module tb_reg_dst_queue;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   passed = 0;
    int   total  = 0;
    int   model_q[$];

    always #5 clk = ~clk;

    reg_dst_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    reg_dst_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LINK_REG(31), .SP_REG(29)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int sel_of(input logic [2:0] code, input int rs, input int rt, input int rd);
        case (code)
            3'b000:  return rs;
            3'b001:  return 31;
            3'b010:  return 29;
            3'b011:  return rt;
            3'b100:  return rd;
            default: return 0;
        endcase
    endfunction

    function automatic bit pending(input int a);
`ifdef REG_DST_HAZARD_CHECK_EN
        if (a == 0) return 1'b0;
        foreach (model_q[i]) if (model_q[i] == a) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic check_state(input string tag, input bit exp_perr, input bit exp_oerr);
        int n;
        n = model_q.size();
        chk({tag, ".count"},     32'(bus.count), 32'(n));
        chk({tag, ".full"},      32'(bus.full), 32'(n == DEPTH));
        chk({tag, ".empty"},     32'(bus.empty), 32'(n == 0));
        chk({tag, ".dst_valid"}, 32'(bus.dst_valid), 32'(n != 0));
        chk({tag, ".dst_out"},   32'(bus.dst_out), (n != 0) ? 32'(model_q[0]) : 32'd0);
        chk({tag, ".push_err"},  32'(bus.push_err), 32'(exp_perr));
        chk({tag, ".pop_err"},   32'(bus.pop_err), 32'(exp_oerr));
    endtask

    // One clock: drive inputs, check hazards before the edge, then outputs after.
    task automatic step(input string tag, input bit ps, input bit pp, input logic [2:0] code,
                        input int rs, input int rt, input int rd);
        bit perr, oerr;
        int n, v;
        bus.push    = ps;
        bus.pop     = pp;
        bus.reg_dst = code;
        bus.rs_addr = ADDR_W'(rs);
        bus.rt_addr = ADDR_W'(rt);
        bus.rd_addr = ADDR_W'(rd);
        #1;
        chk({tag, ".hazard_rs"}, 32'(bus.hazard_rs), 32'(pending(rs)));
        chk({tag, ".hazard_rt"}, 32'(bus.hazard_rt), 32'(pending(rt)));
        n    = model_q.size();
        v    = sel_of(code, rs, rt, rd);
        perr = ps && (n == DEPTH) && !pp;
        oerr = pp && (n == 0);
        if (pp && n > 0) void'(model_q.pop_front());
        if (ps && (n < DEPTH || pp)) model_q.push_back(v);
        @(posedge clk);
        #1;
        check_state(tag, perr, oerr);
    endtask

    task automatic do_reset(input string tag, input bit ps);
        reset_n  = 1'b0;
        bus.push = ps;
        bus.pop  = 1'b0;
        bus.reg_dst = 3'b100;
        bus.rd_addr = 5'd9;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_q.delete();
        check_state(tag, 1'b0, 1'b0);
        chk({tag, ".hazard_rs"}, 32'(bus.hazard_rs), 32'd0);
        chk({tag, ".hazard_rt"}, 32'(bus.hazard_rt), 32'd0);
    endtask

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.reg_dst = 3'b000;
        bus.rs_addr = '0; bus.rt_addr = '0; bus.rd_addr = '0;
        @(posedge clk);
        #1;
        do_reset("reset", 1'b0);

        step("link_push", 1, 0, 3'b001, 0, 0, 0);
        chk("link_dst_is_31", 32'(bus.dst_out), 32'd31);
        step("drain_link", 0, 1, 3'b000, 0, 0, 0);

        step("fill0", 1, 0, 3'b000, 5, 0, 0);
        step("fill1", 1, 0, 3'b010, 0, 0, 0);
        step("fill2", 1, 0, 3'b011, 0, 7, 0);
        step("fill3", 1, 0, 3'b100, 0, 0, 12);
        chk("full_after_4", 32'(bus.full), 32'd1);
        step("push_full", 1, 0, 3'b100, 0, 0, 20);
        step("after_push_err", 0, 0, 3'b000, 0, 0, 0);
        step("push_pop_full", 1, 1, 3'b100, 0, 0, 21);
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 3'b000, 0, 0, 0);
        chk("drained_empty", 32'(bus.empty), 32'd1);

        step("pop_empty", 0, 1, 3'b000, 0, 0, 0);
        step("after_pop_err", 0, 0, 3'b000, 0, 0, 0);
        step("push_pop_empty", 1, 1, 3'b100, 0, 0, 3);
        chk("pp_empty_dst_3", 32'(bus.dst_out), 32'd3);
        step("drain3", 0, 1, 3'b000, 0, 0, 0);

        step("hz_push8", 1, 0, 3'b000, 8, 0, 0);
        step("hz_push0", 1, 0, 3'b000, 0, 0, 0);
        step("hz_probe", 0, 0, 3'b000, 8, 0, 0);
        step("hz_pop8", 0, 1, 3'b000, 8, 8, 0);
        step("hz_after", 0, 0, 3'b000, 8, 0, 0);
        step("hz_drain", 0, 1, 3'b000, 0, 0, 0);

        step("pre_rst0", 1, 0, 3'b100, 0, 0, 1);
        step("pre_rst1", 1, 0, 3'b100, 0, 0, 2);
        step("pre_rst2", 1, 0, 3'b100, 0, 0, 3);
        do_reset("mid_reset", 1'b1);

        step("wrap_seed", 1, 0, 3'b100, 0, 0, 17);
        for (int i = 0; i < 10; i++) step("wrap", 1, 1, 3'b100, 0, 0, i + 1);
        step("wrap_drain", 0, 1, 3'b000, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            int rs, rt;
            bit ps, pp;
            ps = ($urandom_range(0, 99) < 55);
            pp = ($urandom_range(0, 99) < 45);
            rs = $urandom_range(0, 31);
            rt = $urandom_range(0, 31);
            if (model_q.size() > 0 && $urandom_range(0, 1) == 1)
                rs = model_q[$urandom_range(0, model_q.size() - 1)];
            if (model_q.size() > 0 && $urandom_range(0, 1) == 1)
                rt = model_q[$urandom_range(0, model_q.size() - 1)];
            step("rand", ps, pp, 3'($urandom_range(0, 7)), rs, rt, $urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) do_reset("rand_reset", ps);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
